// File: rtl/tl_pkg.sv
// Shared types for the timed traffic-light controller: phase encoding, lamp set and decode.
// The FLASH enumerator is only reachable when FLASH_MODE_EN is defined.
package tl_pkg;

    typedef enum logic [2:0] {
        GR    = 3'd0,
        YR    = 3'd1,
        RR1   = 3'd2,
        RG    = 3'd3,
        RY    = 3'd4,
        RR2   = 3'd5,
        PED   = 3'd6,
        FLASH = 3'd7
    } state_t;

    typedef struct packed {
        logic mg;
        logic my;
        logic mr;
        logic sg;
        logic sy;
        logic sr;
        logic ped;
    } lamp_t;

    function automatic lamp_t lamp_decode(input state_t s, input logic blink);
        lamp_t l;
        l = '0;
        case (s)
            GR:      begin l.mg = 1'b1; l.sr = 1'b1; end
            YR:      begin l.my = 1'b1; l.sr = 1'b1; end
            RG:      begin l.mr = 1'b1; l.sg = 1'b1; end
            RY:      begin l.mr = 1'b1; l.sy = 1'b1; end
            PED:     begin l.mr = 1'b1; l.sr = 1'b1; l.ped = 1'b1; end
            FLASH:   begin l.my = blink; l.sr = blink; end
            default: begin l.mr = 1'b1; l.sr = 1'b1; end
        endcase
        return l;
    endfunction

endpackage

// File: rtl/tl_phase_timer.sv
// Phase down-counter: loads a value, decrements on en while nonzero, flags zero.
module tl_phase_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] value,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = value;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/traffic_light_timed.sv
// Timed, actuated two-road traffic-light controller with pedestrian phase.
// Optional night flash mode is built only when FLASH_MODE_EN is defined.
module traffic_light_timed
    import tl_pkg::*;
#(
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned MAIN_G = 8,
    parameter int unsigned SIDE_G = 4,
    parameter int unsigned YEL    = 2,
    parameter int unsigned ALLRED = 1,
    parameter int unsigned PED_T  = 4
) (
    input  logic   clk,
    input  logic   resetN,
    input  logic   en,
    input  logic   pedButton,
    input  logic   sideCar,
    input  logic   flash,
    output logic   MG,
    output logic   MY,
    output logic   MR,
    output logic   SG,
    output logic   SY,
    output logic   SR,
    output logic   pedLight,
    output logic   pedOn,
    output logic   sideOn,
    output logic   newCycle,
    output state_t phase
);

    localparam logic [63:0] MaxDur = 64'd1 << CNT_W;

    if (MAIN_G < 1 || SIDE_G < 1 || YEL < 1 || ALLRED < 1 || PED_T < 1) begin : g_bad_min
        $fatal(1, "traffic_light_timed: every duration must be >= 1");
    end
    if (64'(MAIN_G) > MaxDur || 64'(SIDE_G) > MaxDur || 64'(YEL) > MaxDur ||
        64'(ALLRED) > MaxDur || 64'(PED_T) > MaxDur) begin : g_bad_max
        $fatal(1, "traffic_light_timed: a duration exceeds 2**CNT_W");
    end

    state_t           state_q, state_d;
    logic             ped_on_q, ped_on_d;
    logic             side_on_q, side_on_d;
    logic             new_cycle_q, new_cycle_d;
    logic             blink;
    logic             load;
    logic             cnt_zero;
    logic [CNT_W-1:0] load_val;
    lamp_t            lamps;

    always_comb begin
        state_d = state_q;
        if (en && cnt_zero) begin
            case (state_q)
                GR:      if (side_on_q || ped_on_q) state_d = YR;
                YR:      state_d = RR1;
                RR1:     state_d = RG;
                RG:      state_d = RY;
                RY:      state_d = RR2;
                RR2:     state_d = ped_on_q ? PED : GR;
                default: state_d = GR;
            endcase
        end
`ifdef FLASH_MODE_EN
        // Flash overrides the normal sequence from any phase.
        if (en) begin
            if (flash) begin
                state_d = FLASH;
            end else if (state_q == FLASH) begin
                state_d = RR2;
            end
        end
`endif
    end

    always_comb begin
        case (resetN ? state_d : GR)
            YR, RY:   load_val = CNT_W'(YEL - 1);
            RR1, RR2: load_val = CNT_W'(ALLRED - 1);
            RG:       load_val = CNT_W'(SIDE_G - 1);
            PED:      load_val = CNT_W'(PED_T - 1);
            default:  load_val = CNT_W'(MAIN_G - 1);
        endcase
        load = !resetN || (state_d != state_q);
    end

    // A new request in the same clk as the clearing transition keeps the latch set.
    always_comb begin
        ped_on_d    = pedButton || (ped_on_q && !(state_d == PED && state_q != PED));
        side_on_d   = sideCar || (side_on_q && !(state_d == RG && state_q != RG));
        new_cycle_d = (state_d == GR) && (state_q != GR);
    end

`ifdef FLASH_MODE_EN
    logic blink_q, blink_d;

    always_comb begin
        blink_d = blink_q;
        if (en) begin
            blink_d = (state_q == FLASH) ? !blink_q : 1'b1;
        end
    end

    assign blink = blink_q;
`else
    logic unused_flash;
    assign unused_flash = flash;
    assign blink        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q     <= GR;
            ped_on_q    <= 1'b0;
            side_on_q   <= 1'b0;
            new_cycle_q <= 1'b0;
`ifdef FLASH_MODE_EN
            blink_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ped_on_q    <= ped_on_d;
            side_on_q   <= side_on_d;
            new_cycle_q <= new_cycle_d;
`ifdef FLASH_MODE_EN
            blink_q     <= blink_d;
`endif
        end
    end

    tl_phase_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk  (clk),
        .load (load),
        .en   (en),
        .value(load_val),
        .zero (cnt_zero)
    );

    assign lamps    = lamp_decode(state_q, blink);
    assign MG       = lamps.mg;
    assign MY       = lamps.my;
    assign MR       = lamps.mr;
    assign SG       = lamps.sg;
    assign SY       = lamps.sy;
    assign SR       = lamps.sr;
    assign pedLight = lamps.ped;
    assign pedOn    = ped_on_q;
    assign sideOn   = side_on_q;
    assign newCycle = new_cycle_q;
    assign phase    = state_q;

endmodule

// File: tb/tb_traffic_light_timed.sv
// Directed bench for traffic_light_timed at default durations (MAIN_G=8, SIDE_G=4, YEL=2,
// ALLRED=1, PED_T=4); flash sequence is exercised only when FLASH_MODE_EN is defined.
module tb_traffic_light_timed;
    import tl_pkg::*;

    // Lamp vector {MG,MY,MR,SG,SY,SR,pedLight}
    localparam logic [6:0] L_GR  = 7'b1000010;
    localparam logic [6:0] L_YR  = 7'b0100010;
    localparam logic [6:0] L_RR  = 7'b0010010;
    localparam logic [6:0] L_RG  = 7'b0011000;
    localparam logic [6:0] L_RY  = 7'b0010100;
    localparam logic [6:0] L_PED = 7'b0010011;

    logic   clk = 1'b0;
    logic   resetN = 1'b1;
    logic   en = 1'b0;
    logic   pedButton = 1'b0;
    logic   sideCar = 1'b0;
    logic   flash = 1'b0;
    logic   MG, MY, MR, SG, SY, SR, pedLight, pedOn, sideOn, newCycle;
    state_t phase;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    traffic_light_timed dut (
        .clk      (clk),
        .resetN   (resetN),
        .en       (en),
        .pedButton(pedButton),
        .sideCar  (sideCar),
        .flash    (flash),
        .MG       (MG),
        .MY       (MY),
        .MR       (MR),
        .SG       (SG),
        .SY       (SY),
        .SR       (SR),
        .pedLight (pedLight),
        .pedOn    (pedOn),
        .sideOn   (sideOn),
        .newCycle (newCycle),
        .phase    (phase)
    );

    typedef struct {
        logic       rst_n;
        logic       en;
        logic       ped;
        logic       side;
        int         rep;
        state_t     ph;
        logic [6:0] lamps;
        logic       ped_on;
        logic       side_on;
        logic       nc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic e, logic p, logic s, int rep, state_t ph,
                                logic [6:0] l, logic po, logic so, logic nc);
        vec_t v;
        v.rst_n = r; v.en = e; v.ped = p; v.side = s; v.rep = rep;
        v.ph = ph; v.lamps = l; v.ped_on = po; v.side_on = so; v.nc = nc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [6:0] lamp_vec();
        return {MG, MY, MR, SG, SY, SR, pedLight};
    endfunction

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            en = 1'b1;
            @(negedge clk);
            en = 1'b0;
        end
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        @(negedge clk);
        resetN = 1'b1;
    endtask

    task automatic pulse_ped();
        pedButton = 1'b1;
        @(negedge clk);
        pedButton = 1'b0;
    endtask

    task automatic pulse_side();
        sideCar = 1'b1;
        @(negedge clk);
        sideCar = 1'b0;
    endtask

    int nc_count;

    initial begin
        // Main side-car then pedestrian cycle, one row per input setting
        vecs.push_back(mk(0, 0, 0, 0, 1, GR,  L_GR,  0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 7, GR,  L_GR,  0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 5, GR,  L_GR,  0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 1, GR,  L_GR,  0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 3, GR,  L_GR,  0, 1, 0));
        vecs.push_back(mk(1, 1, 0, 0, 1, YR,  L_YR,  0, 1, 0));
        vecs.push_back(mk(1, 1, 0, 0, 1, YR,  L_YR,  0, 1, 0));
        vecs.push_back(mk(1, 1, 0, 0, 1, RR1, L_RR,  0, 1, 0));
        vecs.push_back(mk(1, 1, 0, 0, 1, RG,  L_RG,  0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 1, RG,  L_RG,  1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 2, RG,  L_RG,  1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 1, RY,  L_RY,  1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 1, RY,  L_RY,  1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 1, RR2, L_RR,  1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 1, PED, L_PED, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 3, PED, L_PED, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 1, GR,  L_GR,  0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 1, GR,  L_GR,  0, 0, 0));

        @(negedge clk);
        foreach (vecs[i]) begin
            resetN = vecs[i].rst_n;
            en = vecs[i].en;
            pedButton = vecs[i].ped;
            sideCar = vecs[i].side;
            repeat (vecs[i].rep) @(negedge clk);
            chk($sformatf("row%0d phase", i), 32'(phase), 32'(vecs[i].ph));
            chk($sformatf("row%0d lamps", i), 32'(lamp_vec()), 32'(vecs[i].lamps));
            chk($sformatf("row%0d pedOn", i), 32'(pedOn), 32'(vecs[i].ped_on));
            chk($sformatf("row%0d sideOn", i), 32'(sideOn), 32'(vecs[i].side_on));
            chk($sformatf("row%0d newCycle", i), 32'(newCycle), 32'(vecs[i].nc));
        end
        resetN = 1'b1; en = 1'b0; pedButton = 1'b0; sideCar = 1'b0;

        // No requests for 100 ticks: GR held, no newCycle pulse
        do_reset();
        nc_count = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (newCycle) nc_count++;
            chk($sformatf("idle t%0d phase", i), 32'(phase), 32'(GR));
        end
        chk("idle lamps", 32'(lamp_vec()), 32'(L_GR));
        chk("idle newCycle count", 32'(nc_count), 32'd0);

        // pedButton on the same clk as RR2->PED entry keeps pedOn set
        do_reset();
        pulse_ped();
        tick(17);
        chk("pedsame RR2", 32'(phase), 32'(RR2));
        pedButton = 1'b1;
        tick(1);
        pedButton = 1'b0;
        chk("pedsame PED", 32'(phase), 32'(PED));
        chk("pedsame pedOn", 32'(pedOn), 32'd1);
        tick(4);
        chk("pedsame GR", 32'(phase), 32'(GR));
        chk("pedsame newCycle", 32'(newCycle), 32'd1);

        // Reset mid-RG with pedOn latched
        do_reset();
        pulse_ped();
        tick(11);
        chk("rstmid RG", 32'(phase), 32'(RG));
        chk("rstmid pedOn before", 32'(pedOn), 32'd1);
        do_reset();
        chk("rstmid phase", 32'(phase), 32'(GR));
        chk("rstmid pedOn", 32'(pedOn), 32'd0);
        chk("rstmid lamps", 32'(lamp_vec()), 32'(L_GR));
        chk("rstmid newCycle", 32'(newCycle), 32'd0);
        pulse_side();
        tick(7);
        chk("rstmid full MAIN_G hold", 32'(phase), 32'(GR));
        tick(1);
        chk("rstmid full MAIN_G leave", 32'(phase), 32'(YR));

`ifdef FLASH_MODE_EN
        // Flash at tick 3 of RG, blink 1,0,1, then exit via RR2
        do_reset();
        pulse_side();
        tick(13);
        chk("flash pre RG", 32'(phase), 32'(RG));
        flash = 1'b1;
        tick(1);
        chk("flash enter", 32'(phase), 32'(FLASH));
        chk("flash MY1", 32'(MY), 32'd1);
        chk("flash lamps1", 32'(lamp_vec()), 32'b0100010);
        tick(1);
        chk("flash MY2", 32'(MY), 32'd0);
        chk("flash SR2", 32'(SR), 32'd0);
        tick(1);
        chk("flash MY3", 32'(MY), 32'd1);
        flash = 1'b0;
        tick(1);
        chk("flash exit RR2", 32'(phase), 32'(RR2));
        chk("flash exit lamps", 32'(lamp_vec()), 32'(L_RR));
        tick(1);
        chk("flash back GR", 32'(phase), 32'(GR));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
